// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the instruction-fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC owner and imem req/ack fetch FSM feeding the decoder via op_valid/op_ready
// Optional misaligned-redirect trap with HALT state: FETCH_MISALIGN_TRAP_EN
module inst_fetch #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN = fetch_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] I_OP,
  output logic [31:0] pc_out,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);
  import fetch_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;

  assign target = redirect_pc & ~32'h3;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_now;

  // A redirect only counts once a request is live; the post-reset idle cycle ignores it.
  assign trap_now = redirect && (redirect_pc[1:0] != 2'b00) && (state != HALT)
                    && !(state == FETCH && !imem_req);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      I_OP      <= NOP_INSN;
      pc_out    <= RESET_PC;
      op_valid  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
    end else if (trap_now) begin
      state          <= HALT;
      imem_req       <= 1'b0;
      op_valid       <= 1'b0;
      I_OP           <= NOP_INSN;
      fetch_misalign <= 1'b1;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end else if (redirect && imem_ack) begin
            pc        <= target;
            imem_addr <= target;
          end else if (redirect) begin
            pc    <= target;
            state <= DROP;
          end else if (imem_ack) begin
            I_OP     <= imem_rdata;
            pc_out   <= pc;
            op_valid <= 1'b1;
            pc       <= pc + PC_INC;
            imem_req <= 1'b0;
            state    <= HOLD;
          end
        end
        DROP: begin
          // The old address stays on the bus until memory answers; the newest target wins.
          if (imem_ack) begin
            imem_addr <= redirect ? target : pc;
            pc        <= redirect ? target : pc;
            state     <= FETCH;
          end else if (redirect) begin
            pc <= target;
          end
        end
        HOLD: begin
          if (redirect || op_ready) begin
            pc        <= redirect ? target : pc;
            imem_addr <= redirect ? target : pc;
            imem_req  <= 1'b1;
            op_valid  <= 1'b0;
            I_OP      <= NOP_INSN;
            state     <= FETCH;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT: begin
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] I_OP;
  logic [31:0] pc_out;
  logic        op_valid;
  logic        op_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .I_OP        (I_OP),
    .pc_out      (pc_out),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; imem_ack = 1'b0; imem_rdata = '0; op_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    step(); step();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    n_checks++; if (I_OP !== 32'h13) begin n_fail++; $display("FAIL reset_iop: got %h expected 00000013", I_OP); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h expected 00000000", pc_out); end
    n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", op_valid); end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
`endif
  endtask

  task automatic test_stream();
    // A redirect in the idle cycle after reset release must be ignored.
    rstn = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i)); end
      imem_ack = 1'b1; imem_rdata = 32'h33; op_ready = 1'b1;
      step();
      n_checks++; if (op_valid !== 1'b1 || pc_out !== 32'(4 * i) || I_OP !== 32'h33 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_op[%0d]: got valid=%b pc_out=%h iop=%h req=%b expected 1 %h 00000033 0", i, op_valid, pc_out, I_OP, imem_req, 32'(4 * i)); end
      imem_ack = 1'b0;
      step();
      n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap[%0d]: got valid=%b expected 0", i, op_valid); end
    end
  endtask

  task automatic test_wait_hold();
    op_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h expected req=1 addr=0000000c", i, imem_req, imem_addr); end
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (op_valid !== 1'b1 || I_OP !== 32'hDEAD_BEEF || pc_out !== 32'hC || imem_req !== 1'b0) begin n_fail++; $display("FAIL hold[%0d]: got valid=%b iop=%h pc_out=%h req=%b expected 1 deadbeef 0000000c 0", i, op_valid, I_OP, pc_out, imem_req); end
      step();
    end
    n_checks++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL hold_end: got valid=%b expected 1", op_valid); end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    n_checks++; if (op_valid !== 1'b0 || I_OP !== 32'h13 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL hold_release: got valid=%b iop=%h req=%b addr=%h expected 0 00000013 1 00000010", op_valid, I_OP, imem_req, imem_addr); end
  endtask

  task automatic test_hold_redirect();
    imem_ack = 1'b1; imem_rdata = 32'h63;
    step();
    imem_ack = 1'b0;
    n_checks++; if (pc_out !== 32'h10 || op_valid !== 1'b1) begin n_fail++; $display("FAIL branch_op: got pc_out=%h valid=%b expected 00000010 1", pc_out, op_valid); end
    op_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    op_ready = 1'b0; redirect = 1'b0;
    n_checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1 || op_valid !== 1'b0) begin n_fail++; $display("FAIL branch_taken: got addr=%h req=%b valid=%b expected 00000100 1 0", imem_addr, imem_req, op_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h6F;
    step();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h180;
    step();
    redirect = 1'b0;
    n_checks++; if (op_valid !== 1'b0 || I_OP !== 32'h13 || imem_addr !== 32'h180 || imem_req !== 1'b1) begin n_fail++; $display("FAIL flush: got valid=%b iop=%h addr=%h req=%b expected 0 00000013 00000180 1", op_valid, I_OP, imem_addr, imem_req); end
  endtask

  task automatic test_fetch_redirect();
    imem_ack = 1'b1; imem_rdata = 32'h55; redirect = 1'b1; redirect_pc = 32'h20;
    step();
    n_checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1 || op_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_redirect: got addr=%h req=%b valid=%b expected 00000020 1 0", imem_addr, imem_req, op_valid); end
    imem_ack = 1'b0; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1 || op_valid !== 1'b0) begin n_fail++; $display("FAIL drop_wait[%0d]: got addr=%h req=%b valid=%b expected 00000020 1 0", i, imem_addr, imem_req, op_valid); end
      if (i < 2) step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 1'b0;
    n_checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1 || op_valid !== 1'b0 || I_OP !== 32'h13) begin n_fail++; $display("FAIL drop_done: got addr=%h req=%b valid=%b iop=%h expected 00000200 1 0 00000013", imem_addr, imem_req, op_valid, I_OP); end
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL drop_stable: got addr=%h expected 00000200", imem_addr); end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    n_checks++; if (imem_addr !== 32'h400 || op_valid !== 1'b0) begin n_fail++; $display("FAIL last_wins: got addr=%h valid=%b expected 00000400 0", imem_addr, op_valid); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; op_ready = 1'b1; imem_rdata = 32'h77;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got addr=%h expected fffffffc", imem_addr); end
    step();
    imem_ack = 1'b0;
    n_checks++; if (pc_out !== 32'hFFFF_FFFC || I_OP !== 32'h77) begin n_fail++; $display("FAIL wrap_op: got pc_out=%h iop=%h expected fffffffc 00000077", pc_out, I_OP); end
    step();
    op_ready = 1'b0;
    n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_next: got addr=%h req=%b expected 00000000 1", imem_addr, imem_req); end
  endtask

  task automatic test_misalign();
    imem_ack = 1'b1; imem_rdata = 32'h99;
    step();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || op_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_trap: got flag=%b req=%b valid=%b expected 1 0 0", fetch_misalign, imem_req, op_valid); end
    imem_ack = 1'b1; op_ready = 1'b1;
    step(); step();
    imem_ack = 1'b0; op_ready = 1'b0;
    n_checks++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || op_valid !== 1'b0 || I_OP !== 32'h13) begin n_fail++; $display("FAIL misalign_halt: got flag=%b req=%b valid=%b iop=%h expected 1 0 0 00000013", fetch_misalign, imem_req, op_valid, I_OP); end
`else
    n_checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1 || op_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got addr=%h req=%b valid=%b expected 00000100 1 0", imem_addr, imem_req, op_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || op_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got req=%b addr=%h valid=%b expected 0 00000000 0", imem_req, imem_addr, op_valid); end
    step();
    rstn = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step();
    imem_ack = 1'b0;
    n_checks++; if (op_valid !== 1'b0 || I_OP !== 32'h13 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL late_ack: got valid=%b iop=%h req=%b addr=%h expected 0 00000013 1 00000000", op_valid, I_OP, imem_req, imem_addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_cleared: got %b expected 0", fetch_misalign); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_hold();
    test_hold_redirect();
    test_fetch_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
